// File: rtl/calc_pkg.sv
// Shared constants for the calc_seq sequencer: state encoding, error codes
// and default timing parameters.
package calc_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_MUL  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN,
        MUL  = ST_MUL,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DIVZ = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int SER_BITS_DEF = 10;
    localparam int MUL_LAT_DEF  = 2;
    localparam int DIV_TMO_DEF  = 64;
    localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/calc_seq_cnt.sv
// Saturating up-counter with synchronous clear/enable; flags when the count
// sits at MAX-1 (last) or at MAX (term).
module seq_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o,
    output logic term_o
);

    localparam logic [W-1:0] MAX_M1 = MAX - W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, then increment until MAX is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == MAX_M1);
    assign term_o = (cnt_q == MAX);

endmodule

// File: rtl/calc_seq.sv
// Handshaked sequencer for y = a/(a+b+c) * sin(d): load, serial capture in
// parallel with divide, fixed-latency multiply, result strobe or error.
module calc_seq
    import calc_pkg::*;
#(
    parameter int SER_BITS = SER_BITS_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int DIV_TMO  = DIV_TMO_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       div_zero,
    input  logic       div_ok,
    output logic       opd_ld,
    output logic       s2p_en,
    output logic       div_en,
    output logic       mul_en,
    output logic       busy,
    output logic       y_valid,
    output logic       err,
    output logic [1:0] err_code
);

    state_e     state_q;
    state_e     state_d;
    logic       div_done_q;
    logic       err_q;
    logic [1:0] err_code_q;
    logic [1:0] err_code_d;
    logic       err_set_s;
    logic       ser_last_s;
    logic       ser_term_s;
    logic       tmo_last_s;
    logic       tmo_term_s;
    logic       mul_last_s;
    logic       mul_term_s;

    seq_cnt #(.W(CNT_W), .MAX(CNT_W'(SER_BITS))) u_ser_cnt (
        .clk(clk), .rst_i(rst), .clr_i(state_q == LOAD), .en_i(s2p_en),
        .last_o(ser_last_s), .term_o(ser_term_s)
    );

    seq_cnt #(.W(CNT_W), .MAX(CNT_W'(DIV_TMO))) u_tmo_cnt (
        .clk(clk), .rst_i(rst), .clr_i(state_q == LOAD), .en_i(state_q == RUN),
        .last_o(tmo_last_s), .term_o(tmo_term_s)
    );

    seq_cnt #(.W(CNT_W), .MAX(CNT_W'(MUL_LAT))) u_mul_cnt (
        .clk(clk), .rst_i(rst), .clr_i(state_q != MUL), .en_i(mul_en),
        .last_o(mul_last_s), .term_o(mul_term_s)
    );

    // Next state and Moore output decode.
    always_comb begin
        state_d    = state_q;
        opd_ld     = 1'b0;
        s2p_en     = 1'b0;
        div_en     = 1'b0;
        mul_en     = 1'b0;
        y_valid    = 1'b0;
        busy       = (state_q != IDLE);
        err_set_s  = 1'b0;
        err_code_d = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                opd_ld = 1'b1;
                if (div_zero) begin
                    state_d    = ERR;
                    err_set_s  = 1'b1;
                    err_code_d = ERR_DIVZ;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                s2p_en = !ser_term_s;
                div_en = !div_done_q;
                // Timeout beats a div_ok arriving in the same cycle; exit uses the capture finishing now.
                if ((tmo_last_s || tmo_term_s) && !div_done_q) begin
                    state_d    = ERR;
                    err_set_s  = 1'b1;
                    err_code_d = ERR_TMO;
                end else if ((ser_last_s || ser_term_s) && (div_done_q || div_ok)) begin
                    state_d = MUL;
                end else begin
                    state_d = RUN;
                end
            end
            MUL: begin
                mul_en = 1'b1;
                if (mul_last_s || mul_term_s) begin
                    state_d = DONE;
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                y_valid = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky divider-complete flag, armed fresh for each operation.
    always_ff @(posedge clk) begin
        if (rst || (state_q == LOAD)) begin
            div_done_q <= 1'b0;
        end else if ((state_q == RUN) && div_ok) begin
            div_done_q <= 1'b1;
        end else begin
            div_done_q <= div_done_q;
        end
    end

    // Sticky error flag and code, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst || ((state_q == IDLE) && start)) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (err_set_s) begin
            err_q      <= 1'b1;
            err_code_q <= err_code_d;
        end else begin
            err_q      <= err_q;
            err_code_q <= err_code_q;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq: stimulus pushes the predicted outcome of
// each operation, a negedge monitor pops and compares on y_valid or err.
module tb_calc_seq;

    localparam int SER_BITS = 10;
    localparam int MUL_LAT  = 2;
    localparam int DIV_TMO  = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       div_zero;
    logic       div_ok;
    logic       opd_ld, s2p_en, div_en, mul_en, busy, y_valid, err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int kind;   // 0: y_valid, 1: error
        int at;     // absolute cycle of the event
        int code;
        int n_s2p;
        int n_div;
        int n_mul;
    } exp_t;

    exp_t sb[$];

    calc_seq dut (
        .clk(clk), .rst(rst), .start(start), .div_zero(div_zero), .div_ok(div_ok),
        .opd_ld(opd_ld), .s2p_en(s2p_en), .div_en(div_en), .mul_en(mul_en),
        .busy(busy), .y_valid(y_valid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: outcome of one operation from the sequencing rules.
    // mode 0 = divisor zero, mode 1 = div_ok at RUN cycle k (k<0: never).
    function automatic exp_t model(input int mode, input int k, input int sc);
        exp_t e;
        int   run_len;
        if (mode == 0) begin
            e = '{1, sc + 2, 1, 0, 0, 0};
        end else if (k < 0 || k >= DIV_TMO - 1) begin
            e = '{1, sc + 1 + DIV_TMO + 1, 2, (SER_BITS < DIV_TMO) ? SER_BITS : DIV_TMO, DIV_TMO, 0};
        end else begin
            run_len = (k + 1 > SER_BITS) ? k + 1 : SER_BITS;
            e = '{0, sc + 1 + run_len + MUL_LAT + 1, 0, SER_BITS, k + 1, MUL_LAT};
        end
        return e;
    endfunction

    // Monitor: count enables per operation, compare on each output event.
    int   n_s2p = 0, n_div = 0, n_mul = 0;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (opd_ld) begin
            n_s2p = 0; n_div = 0; n_mul = 0;
        end
        if (s2p_en) n_s2p++;
        if (div_en) n_div++;
        if (mul_en) n_mul++;
        if (!rst && (y_valid || (err && !err_prev))) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: y_valid=%0d err=%0d at cycle %0d, expected none", y_valid, err, cyc);
            end else begin
                e = sb.pop_front();
                chk("event_kind", y_valid ? 0 : 1, e.kind);
                chk("event_cycle", cyc, e.at);
                chk("err_code", err_code, e.code);
                chk("s2p_en_cycles", n_s2p, e.n_s2p);
                chk("div_en_cycles", n_div, e.n_div);
                chk("mul_en_cycles", n_mul, e.n_mul);
            end
        end
        err_prev = err;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start    = 1'b0;
            div_ok   = 1'($urandom_range(0, 1));
            div_zero = 1'($urandom_range(0, 1));
        end
    endtask

    // Issue one operation from a negedge in IDLE; returns at the IDLE cycle after it ends.
    task automatic run_op(input int mode, input int k, input bit spur);
        exp_t e;
        int   sc;
        start    = 1'b1;
        div_zero = (mode == 0);
        div_ok   = 1'b0;
        sc       = cyc;
        e        = model(mode, k, sc);
        sb.push_back(e);
        while (cyc != e.at + 1) begin
            @(negedge clk);
            start  = spur && (cyc == sc + 3 || cyc == sc + 8) && (cyc < e.at);
            div_ok = (mode == 1) && (k >= 0) && (cyc == sc + 2 + k);
            if (cyc > sc + 1) div_zero = 1'($urandom_range(0, 1));
            if (cyc == sc + 1) begin
                chk("busy_in_load", busy, 1);
                chk("err_cleared_by_start", err, 0);
            end
        end
        chk("event_seen", sb.size(), 0);
        chk("busy_after_op", busy, 0);
        chk("err_sticky", err, e.kind);
        if (e.kind == 1) chk("err_code_sticky", err_code, e.code);
    endtask

    // Abort a normal operation with rst in its first MUL cycle.
    task automatic reset_in_mul();
        int sc;
        start    = 1'b1;
        div_zero = 1'b0;
        div_ok   = 1'b0;
        sc       = cyc;
        while (cyc != sc + 12) begin
            @(negedge clk);
            start  = 1'b0;
            div_ok = (cyc == sc + 6);
        end
        chk("mul_before_abort", mul_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("outputs_after_abort", {opd_ld, s2p_en, div_en, mul_en, busy, y_valid, err, err_code}, 0);
        rst = 1'b0;
        idle(4);
    endtask

    initial begin
        int r;
        rst      = 1'b1;
        start    = 1'b0;
        div_zero = 1'b0;
        div_ok   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {opd_ld, s2p_en, div_en, mul_en, busy, y_valid, err, err_code}, 0);
        rst = 1'b0;
        idle(2);

        run_op(1, 4, 1'b1);
        run_op(1, 20, 1'b0);
        idle(1);
        run_op(0, 0, 1'b0);
        idle(2);
        run_op(1, -1, 1'b0);
        run_op(1, 4, 1'b0);
        run_op(1, 62, 1'b0);
        run_op(1, 63, 1'b0);
        run_op(1, 9, 1'b0);
        run_op(1, 10, 1'b0);
        run_op(1, 0, 1'b0);
        idle(1);
        reset_in_mul();
        run_op(1, 4, 1'b0);

        for (int n = 0; n < 30; n++) begin
            idle($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0)      run_op(0, 0, 1'($urandom_range(0, 1)));
            else if (r == 1) run_op(1, -1, 1'($urandom_range(0, 1)));
            else             run_op(1, $urandom_range(0, 40), 1'($urandom_range(0, 1)));
        end

        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
